key_schedule_ctrl: RTL
======================

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 Parameter NR, default 10, number of AES-128 rounds; 10 is the only legal value.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 key_valid  input  1  cipher key offered on key.
REQ-005 key  input  128  cipher key; w0 = key[127:96] ... w3 = key[31:0].
REQ-006 key_ready  output  1  block accepts a key this cycle.
REQ-007 busy  output  1  expansion in progress.
REQ-008 keys_valid  output  1  all NR+1 round keys stored and stable.
REQ-009 rk_addr  input  4  round-key read index, 0..10.
REQ-010 rk_data  output  128  round key selected by rk_addr, as {w4i, w4i+1, w4i+2, w4i+3}.

Function
REQ-011 The block SHALL have states IDLE, EXPAND and DONE, encoded in a registered state variable.
REQ-012 key_ready SHALL be 1 in IDLE and DONE and 0 in EXPAND.
REQ-013 A handshake is key_valid & key_ready sampled at a rising edge; key_valid in EXPAND SHALL be ignored.
REQ-014 On a handshake edge the block SHALL write key into rk[0], set round counter rc to 1, and go to EXPAND.
REQ-015 In EXPAND, each edge SHALL compute round key rc from rk[rc-1] using one function_g instance with round input rc, then write rk[rc] and increment rc.
REQ-016 Words SHALL follow the AES-128 chain: w4i = w4i-4 ^ g(w4i-1); each later word is the previous new word XOR the word four positions back.
REQ-017 On the edge that writes rk[10], the block SHALL go to DONE and set keys_valid to 1.
REQ-018 Latency: keys_valid SHALL rise exactly 10 cycles after the handshake edge.
REQ-019 busy SHALL equal 1 exactly while in EXPAND.
REQ-020 A handshake in DONE SHALL restart expansion: keys_valid falls on that edge and rk[0] is overwritten.
REQ-021 A handshake in IDLE and one in DONE SHALL behave identically apart from the state they leave.
REQ-022 rk_data SHALL be a combinational read of rk[rk_addr]; rk_addr values 11..15 SHALL return all zeros.
REQ-023 During EXPAND, entries with index below rc hold the new key's values; entries from rc to 10 hold stale data; keys_valid=0 marks the whole table invalid.
REQ-024 rc SHALL be 4 bits wide and SHALL NOT wrap; after 10 the state leaves EXPAND.

Reset
REQ-025 When rst=1 at an edge, the block SHALL enter IDLE and set rc=0, keys_valid=0, busy=0, key_ready=1, and clear every rk entry to zero.
REQ-026 rst SHALL take priority over a concurrent handshake and over an expansion in progress; a partly expanded schedule is discarded.
REQ-027 After reset is released, the first handshake SHALL behave as in REQ-014.

Structure
REQ-028 Shared package key_sched_pkg SHALL hold: NR; the state encoding; the round-key width (128); the word width (32); the index width (4).
REQ-029 The block SHALL instantiate exactly one function_g (32-bit word in, 4-bit round in, 32-bit word out); there SHALL be no unrolled multi-round expansion.
REQ-030 The rk table SHALL be 11x128-bit registers; no other sub-modules.

Verification
REQ-031 Key 2b7e151628aed2a6abf7158809cf4f3c -> 10 cycles later keys_valid=1; rk[1]=a0fafe1788542cb123a339392a6c7605; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 Key all-zero -> rk[1]=62636363626363636263636362636363; rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-033 rst pulsed 4 cycles after a handshake -> next cycle: state IDLE, key_valid ignored, rk_data=0 for addresses 0..10, keys_valid=0.
REQ-034 key_valid held high in EXPAND with a different key -> it is ignored; results match REQ-031.
REQ-035 Re-key in DONE with the zero key after the REQ-031 key -> keys_valid drops for 10 cycles, then the REQ-032 values are read.
REQ-036 rk_addr=11 and rk_addr=15 in DONE -> rk_data=0.

Source files
------------

// File: rtl/key_sched_pkg.sv
// Shared constants, state encoding and byte-level helpers for the AES-128
// key schedule controller.
package key_sched_pkg;

   localparam int NR     = 10;
   localparam int RK_W   = 128;
   localparam int WORD_W = 32;
   localparam int IDX_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Element 0 of the table sits in the most significant byte.
   localparam logic [0:255][7:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[b];
   endfunction

   function automatic logic [7:0] rcon(input logic [IDX_W-1:0] round);
      logic [7:0] r;
      case (round)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/key_schedule_ctrl_function_g.sv
// AES key-schedule g(): RotWord, SubWord, then XOR the round constant into
// the top byte.
module function_g
   import key_sched_pkg::*;
(
   input  logic [WORD_W-1:0] word_i,
   input  logic [IDX_W-1:0]  round_i,
   output logic [WORD_W-1:0] word_o
);

   logic [WORD_W-1:0] rot;
   logic [WORD_W-1:0] sub;

   always_comb begin
      rot = {word_i[23:0], word_i[31:24]};
      sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
      word_o = sub ^ {rcon(round_i), 24'h000000};
   end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key expansion: one round key per cycle into an 11-entry
// table, with a combinational read port.
module key_schedule_ctrl #(
   parameter int NR = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   key_valid,
   input  logic [127:0]           key,
   output logic                   key_ready,
   output logic                   busy,
   output logic                   keys_valid,
   input  logic [3:0]             rk_addr,
   output logic [127:0]           rk_data,
   output key_sched_pkg::state_t  dbg_state
);
   import key_sched_pkg::*;

   // Handshake: a key is taken on any rising edge where key_valid and
   // key_ready are both high; key_ready is low for the whole expansion.
   localparam logic [IDX_W-1:0] LAST_RC = IDX_W'(NR);

   state_t              state_q;
   logic [IDX_W-1:0]    rc_q;
   logic [RK_W-1:0]     rk_q [NR+1];
   logic                key_ready_q;
   logic                busy_q;
   logic                keys_valid_q;

   logic                handshake;
   logic [IDX_W-1:0]    prev_idx;
   logic [RK_W-1:0]     prev_rk;
   logic [RK_W-1:0]     rk_d;
   logic [WORD_W-1:0]   g_out;
   logic [WORD_W-1:0]   w0, w1, w2, w3;

   function_g u_g (
      .word_i  (prev_rk[31:0]),
      .round_i (rc_q),
      .word_o  (g_out)
   );

   always_comb begin
      handshake = key_valid & key_ready_q;
      prev_idx  = (rc_q == '0) ? '0 : rc_q - 1'b1;
      prev_rk   = rk_q[prev_idx];
      w0        = prev_rk[127:96] ^ g_out;
      w1        = prev_rk[95:64]  ^ w0;
      w2        = prev_rk[63:32]  ^ w1;
      w3        = prev_rk[31:0]   ^ w2;
      rk_d      = {w0, w1, w2, w3};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rc_q         <= '0;
         key_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         keys_valid_q <= 1'b0;
         for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (handshake) begin
                  rk_q[0]      <= key;
                  rc_q         <= 4'd1;
                  state_q      <= ST_EXPAND;
                  key_ready_q  <= 1'b0;
                  busy_q       <= 1'b1;
                  keys_valid_q <= 1'b0;
               end
            end
            ST_EXPAND: begin
               rk_q[rc_q] <= rk_d;
               rc_q       <= rc_q + 1'b1;
               if (rc_q == LAST_RC) begin
                  state_q      <= ST_DONE;
                  key_ready_q  <= 1'b1;
                  busy_q       <= 1'b0;
                  keys_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               key_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      rk_data = '0;
      if (rk_addr <= LAST_RC) rk_data = rk_q[rk_addr];
   end

   assign key_ready  = key_ready_q;
   assign busy       = busy_q;
   assign keys_valid = keys_valid_q;
   assign dbg_state  = state_q;

endmodule
